// File: rtl/egg_timer.sv
// Egg-timer core: captures an MM:SS preset from four BCD digit inputs and
// counts it down to 00:00 under a five-state controller. TICK_DIV sets the
// number of clock cycles per one-second tick.
module egg_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       cook_time,
    input  logic [3:0] load1,
    input  logic [2:0] load2,
    input  logic [3:0] load3,
    input  logic [2:0] load4,
    output logic [3:0] load1_temp,
    output logic [2:0] load2_temp,
    output logic [3:0] load3_temp,
    output logic [2:0] load4_temp,
    output logic [3:0] s_ones_Down,
    output logic [2:0] s_tens_Down,
    output logic [3:0] m_ones_Down,
    output logic [2:0] m_tens_Down,
    output logic [2:0] z,
    output logic       timer_enabled,
    output logic       timer_on
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SET   = 3'd2,
        S_COUNT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] tick_cnt_q;

    logic [3:0] ld1_c;
    logic [2:0] ld2_c;
    logic [3:0] ld3_c;
    logic [2:0] ld4_c;

    logic [3:0] s_ones_d;
    logic [2:0] s_tens_d;
    logic [3:0] m_ones_d;
    logic [2:0] m_tens_d;

    logic at_zero_c;
    logic dec_zero_c;
    logic preset_zero_c;
    logic tick_fire_c;

    // Clamp out-of-range digits so captured values are always valid BCD time.
    assign ld1_c = (load1 > 4'd9) ? 4'd9 : load1;
    assign ld2_c = (load2 > 3'd5) ? 3'd5 : load2;
    assign ld3_c = (load3 > 4'd9) ? 4'd9 : load3;
    assign ld4_c = (load4 > 3'd5) ? 3'd5 : load4;

    assign at_zero_c     = (s_ones_Down == 4'd0) && (s_tens_Down == 3'd0) &&
                           (m_ones_Down == 4'd0) && (m_tens_Down == 3'd0);
    assign dec_zero_c    = (s_ones_d == 4'd0) && (s_tens_d == 3'd0) &&
                           (m_ones_d == 4'd0) && (m_tens_d == 3'd0);
    assign preset_zero_c = (load1_temp == 4'd0) && (load2_temp == 3'd0) &&
                           (load3_temp == 4'd0) && (load4_temp == 3'd0);
    assign tick_fire_c   = (tick_cnt_q == TICK_LAST);

    // One-second BCD decrement of MM:SS with borrow ripple between digits.
    always_comb begin
        s_ones_d = s_ones_Down;
        s_tens_d = s_tens_Down;
        m_ones_d = m_ones_Down;
        m_tens_d = m_tens_Down;
        if (s_ones_Down != 4'd0) begin
            s_ones_d = s_ones_Down - 4'd1;
        end else begin
            s_ones_d = 4'd9;
            if (s_tens_Down != 3'd0) begin
                s_tens_d = s_tens_Down - 3'd1;
            end else begin
                s_tens_d = 3'd5;
                if (m_ones_Down != 4'd0) begin
                    m_ones_d = m_ones_Down - 4'd1;
                end else begin
                    m_ones_d = 4'd9;
                    m_tens_d = m_tens_Down - 3'd1;
                end
            end
        end
    end

    // Controller, preset capture, countdown digits and tick prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            load1_temp  <= 4'd0;
            load2_temp  <= 3'd0;
            load3_temp  <= 4'd0;
            load4_temp  <= 3'd0;
            s_ones_Down <= 4'd0;
            s_tens_Down <= 3'd0;
            m_ones_Down <= 4'd0;
            m_tens_Down <= 3'd0;
        end else if (!enable) begin
            // Disabled: behave as IDLE from any state; any count in flight is lost.
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            load1_temp  <= ld1_c;
            load2_temp  <= ld2_c;
            load3_temp  <= ld3_c;
            load4_temp  <= ld4_c;
            s_ones_Down <= 4'd0;
            s_tens_Down <= 3'd0;
            m_ones_Down <= 4'd0;
            m_tens_Down <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tick_cnt_q  <= '0;
                    load1_temp  <= ld1_c;
                    load2_temp  <= ld2_c;
                    load3_temp  <= ld3_c;
                    load4_temp  <= ld4_c;
                    s_ones_Down <= 4'd0;
                    s_tens_Down <= 3'd0;
                    m_ones_Down <= 4'd0;
                    m_tens_Down <= 3'd0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    tick_cnt_q  <= '0;
                    s_ones_Down <= load1_temp;
                    s_tens_Down <= load2_temp;
                    m_ones_Down <= load3_temp;
                    m_tens_Down <= load4_temp;
                    if (cook_time) begin
                        state_q <= S_SET;
                    end else if (start) begin
                        state_q <= preset_zero_c ? S_DONE : S_COUNT;
                    end
                end
                S_SET: begin
                    load1_temp  <= ld1_c;
                    load2_temp  <= ld2_c;
                    load3_temp  <= ld3_c;
                    load4_temp  <= ld4_c;
                    s_ones_Down <= ld1_c;
                    s_tens_Down <= ld2_c;
                    m_ones_Down <= ld3_c;
                    m_tens_Down <= ld4_c;
                    if (!cook_time) begin
                        state_q <= S_WAIT;
                    end
                end
                S_COUNT: begin
                    if (at_zero_c) begin
                        state_q <= S_DONE;
                    end else if (tick_fire_c) begin
                        tick_cnt_q  <= '0;
                        s_ones_Down <= s_ones_d;
                        s_tens_Down <= s_tens_d;
                        m_ones_Down <= m_ones_d;
                        m_tens_Down <= m_tens_d;
                        if (dec_zero_c) begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    s_ones_Down <= 4'd0;
                    s_tens_Down <= 3'd0;
                    m_ones_Down <= 4'd0;
                    m_tens_Down <= 3'd0;
                    if (!start) begin
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    tick_cnt_q  <= '0;
                    s_ones_Down <= 4'd0;
                    s_tens_Down <= 3'd0;
                    m_ones_Down <= 4'd0;
                    m_tens_Down <= 3'd0;
                end
            endcase
        end
    end

    // Status decoded from the state register.
    assign z             = state_q;
    assign timer_enabled = (state_q != S_IDLE);
    assign timer_on      = (state_q == S_COUNT);

endmodule

// File: tb/tb_egg_timer.sv
// Bench for egg_timer: directed vector table, hand-written countdown corner
// sequences, then random stimulus against a seconds-based reference model.
module tb_egg_timer;

    localparam int unsigned TD = 1;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       start;
    logic       cook_time;
    logic [3:0] load1;
    logic [2:0] load2;
    logic [3:0] load3;
    logic [2:0] load4;
    logic [3:0] load1_temp;
    logic [2:0] load2_temp;
    logic [3:0] load3_temp;
    logic [2:0] load4_temp;
    logic [3:0] s_ones_Down;
    logic [2:0] s_tens_Down;
    logic [3:0] m_ones_Down;
    logic [2:0] m_tens_Down;
    logic [2:0] z;
    logic       timer_enabled;
    logic       timer_on;

    int n_pass;
    int n_total;

    // Reference model: state code, preset digits, remaining seconds, tick phase.
    int m_state;
    int m_t1, m_t2, m_t3, m_t4;
    int m_rem;
    int m_cnt;

    typedef struct {
        bit          rst, en, st, ck;
        int          l1, l2, l3, l4;
        int          ez;
        logic [15:0] tmp;
        logic [15:0] dn;
        bit          te, ton;
    } vec_t;

    vec_t vecs[$];

    egg_timer #(.TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .start        (start),
        .cook_time    (cook_time),
        .load1        (load1),
        .load2        (load2),
        .load3        (load3),
        .load4        (load4),
        .load1_temp   (load1_temp),
        .load2_temp   (load2_temp),
        .load3_temp   (load3_temp),
        .load4_temp   (load4_temp),
        .s_ones_Down  (s_ones_Down),
        .s_tens_Down  (s_tens_Down),
        .m_ones_Down  (m_ones_Down),
        .m_tens_Down  (m_tens_Down),
        .z            (z),
        .timer_enabled(timer_enabled),
        .timer_on     (timer_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit e, bit s, bit c, int a, int b, int cc, int d,
                                int ez, logic [15:0] t, logic [15:0] dn, bit te, bit ton);
        vec_t v;
        v.rst = r; v.en = e; v.st = s; v.ck = c;
        v.l1 = a; v.l2 = b; v.l3 = cc; v.l4 = d;
        v.ez = ez; v.tmp = t; v.dn = dn; v.te = te; v.ton = ton;
        return v;
    endfunction

    function automatic int clampi(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [15:0] secs_to_bcd(int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input bit r, input bit e, input bit s, input bit c,
                        input int a, input int b, input int cc, input int d);
        reset = r; enable = e; start = s; cook_time = c;
        load1 = 4'(a); load2 = 3'(b); load3 = 4'(cc); load4 = 3'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int ez, input logic [15:0] et,
                       input logic [15:0] ed, input bit ete, input bit eton);
        logic [15:0] at;
        logic [15:0] ad;
        at = {1'b0, load4_temp, load3_temp, 1'b0, load2_temp, load1_temp};
        ad = {1'b0, m_tens_Down, m_ones_Down, 1'b0, s_tens_Down, s_ones_Down};
        n_total++;
        if (z === 3'(ez) && at === et && ad === ed &&
            timer_enabled === ete && timer_on === eton) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got z=%0d tmp=%h dn=%h en=%b on=%b, expected z=%0d tmp=%h dn=%h en=%b on=%b",
                     name, $time, z, at, ad, timer_enabled, timer_on, ez, et, ed, ete, eton);
        end
    endtask

    // Model update for one clock edge, in whole seconds rather than BCD digits.
    task automatic model_step(input bit r, input bit e, input bit s, input bit c,
                              input int a, input int b, input int cc, input int d);
        int c1, c2, c3, c4, preset;
        c1 = clampi(a, 9); c2 = clampi(b, 5); c3 = clampi(cc, 9); c4 = clampi(d, 5);
        preset = m_t4 * 600 + m_t3 * 60 + m_t2 * 10 + m_t1;
        if (r) begin
            m_state = 0; m_t1 = 0; m_t2 = 0; m_t3 = 0; m_t4 = 0; m_rem = 0; m_cnt = 0;
        end else if (!e) begin
            m_state = 0; m_t1 = c1; m_t2 = c2; m_t3 = c3; m_t4 = c4; m_rem = 0; m_cnt = 0;
        end else begin
            case (m_state)
                0: begin
                    m_t1 = c1; m_t2 = c2; m_t3 = c3; m_t4 = c4;
                    m_rem = 0; m_cnt = 0; m_state = 1;
                end
                1: begin
                    m_rem = preset; m_cnt = 0;
                    if (c) m_state = 2;
                    else if (s) m_state = (preset != 0) ? 3 : 4;
                end
                2: begin
                    m_t1 = c1; m_t2 = c2; m_t3 = c3; m_t4 = c4;
                    m_rem = c4 * 600 + c3 * 60 + c2 * 10 + c1;
                    if (!c) m_state = 1;
                end
                3: begin
                    m_cnt++;
                    if (m_cnt == int'(TD)) begin
                        m_cnt = 0;
                        m_rem--;
                        if (m_rem == 0) m_state = 4;
                    end
                end
                default: begin
                    m_rem = 0;
                    if (!s) m_state = 1;
                end
            endcase
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, m_state, {4'(m_t4), 4'(m_t3), 4'(m_t2), 4'(m_t1)}, secs_to_bcd(m_rem),
            m_state != 0, m_state == 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_pass = 0;
        n_total = 0;
        m_state = 0; m_t1 = 0; m_t2 = 0; m_t3 = 0; m_t4 = 0; m_rem = 0; m_cnt = 0;
        reset = 1'b1; enable = 1'b0; start = 1'b0; cook_time = 1'b0;
        load1 = 4'd0; load2 = 3'd0; load3 = 4'd0; load4 = 3'd0;

        // Reset, 24:44 preset and first decrements.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0, 4,4,4,2, 0,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,1,0,0, 4,4,4,2, 1,16'h2444,16'h0000,1,0));
        vecs.push_back(mk(0,1,0,0, 4,4,4,2, 1,16'h2444,16'h2444,1,0));
        vecs.push_back(mk(0,1,1,0, 4,4,4,2, 3,16'h2444,16'h2444,1,1));
        vecs.push_back(mk(0,1,1,0, 4,4,4,2, 3,16'h2444,16'h2443,1,1));
        vecs.push_back(mk(0,1,0,0, 4,4,4,2, 3,16'h2444,16'h2442,1,1));
        vecs.push_back(mk(0,1,0,1, 4,4,4,2, 3,16'h2444,16'h2441,1,1));
        vecs.push_back(mk(0,1,1,0, 4,4,4,2, 3,16'h2444,16'h2440,1,1));
        vecs.push_back(mk(0,1,1,0, 4,4,4,2, 3,16'h2444,16'h2439,1,1));
        // 00:03 countdown into DONE, then back to WAIT.
        vecs.push_back(mk(1,1,0,0, 3,0,0,0, 0,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,1,0,0, 3,0,0,0, 1,16'h0003,16'h0000,1,0));
        vecs.push_back(mk(0,1,0,0, 3,0,0,0, 1,16'h0003,16'h0003,1,0));
        vecs.push_back(mk(0,1,1,0, 3,0,0,0, 3,16'h0003,16'h0003,1,1));
        vecs.push_back(mk(0,1,1,0, 3,0,0,0, 3,16'h0003,16'h0002,1,1));
        vecs.push_back(mk(0,1,1,0, 3,0,0,0, 3,16'h0003,16'h0001,1,1));
        vecs.push_back(mk(0,1,1,0, 3,0,0,0, 4,16'h0003,16'h0000,1,0));
        vecs.push_back(mk(0,1,1,0, 3,0,0,0, 4,16'h0003,16'h0000,1,0));
        vecs.push_back(mk(0,1,0,0, 3,0,0,0, 1,16'h0003,16'h0000,1,0));
        vecs.push_back(mk(0,1,0,0, 3,0,0,0, 1,16'h0003,16'h0003,1,0));
        // SET editing and clamping; SET beats start in WAIT.
        vecs.push_back(mk(0,1,0,1, 9,5,9,5, 2,16'h0003,16'h0003,1,0));
        vecs.push_back(mk(0,1,0,1, 9,5,9,5, 2,16'h5959,16'h5959,1,0));
        vecs.push_back(mk(0,1,0,0, 1,2,3,4, 1,16'h4321,16'h4321,1,0));
        vecs.push_back(mk(0,1,0,1, 15,7,12,6, 2,16'h4321,16'h4321,1,0));
        vecs.push_back(mk(0,1,0,1, 15,7,12,6, 2,16'h5959,16'h5959,1,0));
        vecs.push_back(mk(0,1,0,0, 15,7,15,7, 1,16'h5959,16'h5959,1,0));
        vecs.push_back(mk(0,1,1,1, 15,7,15,7, 2,16'h5959,16'h5959,1,0));
        vecs.push_back(mk(0,1,1,0, 15,7,15,7, 1,16'h5959,16'h5959,1,0));
        // Count with loads ignored, then enable drop mid-count.
        vecs.push_back(mk(0,1,1,0, 1,1,1,1, 3,16'h5959,16'h5959,1,1));
        vecs.push_back(mk(0,1,1,0, 15,7,15,7, 3,16'h5959,16'h5958,1,1));
        vecs.push_back(mk(0,0,1,0, 15,7,15,7, 0,16'h5959,16'h0000,0,0));
        // Zero preset goes straight to DONE.
        vecs.push_back(mk(0,1,0,0, 0,0,0,0, 1,16'h0000,16'h0000,1,0));
        vecs.push_back(mk(0,1,1,0, 0,0,0,0, 4,16'h0000,16'h0000,1,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0,0, 1,16'h0000,16'h0000,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.rst, v.en, v.st, v.ck, v.l1, v.l2, v.l3, v.l4);
            chk($sformatf("vec%0d", i), v.ez, v.tmp, v.dn, v.te, v.ton);
        end

        // Minute borrow: 24:44 runs down to 24:00, next tick shows 23:59.
        step(1,0,0,0, 4,4,4,2);
        step(0,1,0,0, 4,4,4,2);
        step(0,1,1,0, 4,4,4,2);
        for (int i = 0; i < 44; i++) step(0,1,1,0, 4,4,4,2);
        chk("roll_2400", 3, 16'h2444, 16'h2400, 1, 1);
        step(0,1,1,0, 4,4,4,2);
        chk("roll_2359", 3, 16'h2444, 16'h2359, 1, 1);

        // Ten-minute borrow: 10:00 -> 09:59.
        step(1,0,0,0, 0,0,0,1);
        step(0,1,0,0, 0,0,0,1);
        step(0,1,1,0, 0,0,0,1);
        chk("ten_1000", 3, 16'h1000, 16'h1000, 1, 1);
        step(0,1,1,0, 0,0,0,1);
        chk("ten_0959", 3, 16'h1000, 16'h0959, 1, 1);

        // Random stimulus against the reference model.
        step(1,0,0,0, 0,0,0,0);
        model_step(1,0,0,0, 0,0,0,0);
        chk_model("rand_reset");
        for (int i = 0; i < 4000; i++) begin
            bit r, e, s, c;
            int a, b, cc, d;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 59) != 0);
            s = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 4); b = $urandom_range(0, 1); cc = 0; d = 0;
            end else begin
                a = $urandom_range(0, 15); b = $urandom_range(0, 7);
                cc = $urandom_range(0, 15); d = $urandom_range(0, 7);
            end
            step(r, e, s, c, a, b, cc, d);
            model_step(r, e, s, c, a, b, cc, d);
            chk_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
